adder_rr_arbiter: RTL and testbench

//  Shares one N-bit structural ripple-carry adder (fullAdder_32bit_struct) among NREQ requesters.
//  - Round-robin grant; valid/ready handshake on each request port.
//  - One registered response slot, tagged with the requester id.
//  - Sits between the client units and the single adder instance in the datapath.

---
 rtl/adder_arb_pkg.sv | 9 +
 rtl/adder_rr_pick.sv | 35 +++
 rtl/fullAdder_32bit_struct.sv | 33 +++
 rtl/adder_rr_arbiter.sv | 90 +++++++++
 tb/tb_adder_rr_arbiter.sv | 138 +++++++++++++
 5 files changed

// File: rtl/adder_arb_pkg.sv
// Shared types and defaults for the round-robin adder arbiter.
//   arb_state_t : response-slot state (IDLE = empty, FULL = holds a result)
//   DEF_N       : default operand/sum width
//   DEF_NREQ    : default number of requesters
package adder_arb_pkg;
  typedef enum logic {IDLE, FULL} arb_state_t;
  localparam int DEF_N    = 32;
  localparam int DEF_NREQ = 4;
endpackage

// File: rtl/adder_rr_pick.sv
// Combinational round-robin picker.
//   req_valid  : request bit per requester
//   last_grant : id of the previous winner; search starts one past it
//   grant_oh   : one-hot winner (all zero when nothing is requesting)
//   grant_id   : winner id
//   any_valid  : at least one request present
module adder_rr_pick #(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [ID_W-1:0] last_grant,
  output logic [NREQ-1:0] grant_oh,
  output logic [ID_W-1:0] grant_id,
  output logic            any_valid
);
  int idx;

  always_comb begin
    grant_oh  = '0;
    grant_id  = '0;
    any_valid = 1'b0;
    idx       = 0;
    // Walk NREQ positions starting after last_grant; the last one visited is
    // last_grant itself, so a lone requester always wins.
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_grant) + k) % NREQ;
      if (!any_valid && req_valid[idx]) begin
        any_valid     = 1'b1;
        grant_oh[idx] = 1'b1;
        grant_id      = ID_W'(idx);
      end
    end
  end
endmodule

// File: rtl/fullAdder_32bit_struct.sv
// Structural ripple-carry adder built from an array of one-bit cells.
//   a, b : N-bit operands
//   sum  : (a + b) mod 2^N; the carry out of the top bit is not produced
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module fullAdder_32bit_struct #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum
);
  logic [N-1:0] c;
  assign c[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_bit
    if (i == N-1) begin : g_top
      // Top bit needs no carry out: the sum wraps modulo 2^N.
      assign sum[i] = a[i] ^ b[i] ^ c[i];
    end else begin : g_fa
      fa_bit u_fa (.a(a[i]), .b(b[i]), .ci(c[i]), .s(sum[i]), .co(c[i+1]));
    end
  end
endmodule

// File: rtl/adder_rr_arbiter.sv
// Shares one structural ripple-carry adder among NREQ requesters with a
// round-robin grant and a single registered, id-tagged response slot.
//   clk, rst_n          : clock, async active-low reset
//   req_valid/req_ready : per-requester handshake (at most one ready bit)
//   req_a, req_b        : flat operand buses, slice i = [i*N +: N]
//   rsp_valid/rsp_ready : response slot handshake
//   rsp_id, rsp_sum     : owner id and result of the held response
// Build option ADDER_RR_SAT_EN: unsigned saturation instead of wrap-around.
module adder_rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter int N    = DEF_N,
  parameter int NREQ = DEF_NREQ,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ID_W-1:0]   rsp_id,
  output logic [N-1:0]      rsp_sum
);
  arb_state_t state, state_nxt;
  logic [ID_W-1:0] last_grant;
  logic [NREQ-1:0] grant_oh;
  logic [ID_W-1:0] grant_id;
  logic            any_valid;
  logic            accept, take;
  logic [NREQ-1:0][N-1:0] a_vec, b_vec;
  logic [N-1:0]    a_sel, b_sel, sum_raw, sum_d;

  assign a_vec = req_a;
  assign b_vec = req_b;

  adder_rr_pick #(.NREQ(NREQ), .ID_W(ID_W)) u_pick (
    .req_valid (req_valid),
    .last_grant(last_grant),
    .grant_oh  (grant_oh),
    .grant_id  (grant_id),
    .any_valid (any_valid)
  );

  // Gated by rst_n so nothing is offered while reset is held.
  assign accept    = rst_n & ((state == IDLE) | (rsp_valid & rsp_ready));
  assign req_ready = grant_oh & {NREQ{accept}};
  assign take      = any_valid & accept;
  assign rsp_valid = (state == FULL);

  assign a_sel = a_vec[grant_id];
  assign b_sel = b_vec[grant_id];

  fullAdder_32bit_struct #(.N(N)) u_add (.a(a_sel), .b(b_sel), .sum(sum_raw));

`ifdef ADDER_RR_SAT_EN
  // Unsigned overflow shows up as a wrapped sum below an operand.
  assign sum_d = (sum_raw < a_sel) ? {N{1'b1}} : sum_raw;
`else
  assign sum_d = sum_raw;
`endif

  always_comb begin
    state_nxt = state;
    if (take)
      state_nxt = FULL;
    else if (rsp_valid && rsp_ready)
      state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // last_grant moves only on a handshake so idle cycles keep fairness.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_sum    <= '0;
      rsp_id     <= '0;
      last_grant <= ID_W'(NREQ-1);
    end else if (take) begin
      rsp_sum    <= sum_d;
      rsp_id     <= grant_id;
      last_grant <= grant_id;
    end
  end
endmodule

// File: tb/tb_adder_rr_arbiter.sv
module tb_adder_rr_arbiter;
  localparam int N = 32, NREQ = 4, ID_W = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [NREQ*N-1:0] req_a, req_b;
  logic              rsp_valid, rsp_ready;
  logic [ID_W-1:0]   rsp_id;
  logic [N-1:0]      rsp_sum;
  int checks = 0, errors = 0;

  adder_rr_arbiter #(.N(N), .NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*N +: N] = a;
    req_b[i*N +: N] = b;
  endtask

  initial begin
    int ord [5] = '{0, 1, 2, 3, 0};
    logic [31:0] exp_wrap;
`ifdef ADDER_RR_SAT_EN
    exp_wrap = 32'hFFFF_FFFF;
`else
    exp_wrap = 32'h0000_0001;
`endif
    req_a = '0; req_b = '0;
    for (int i = 0; i < NREQ; i++) set_op(i, 32'd100 * (i + 1), 32'd7);

    // T1 reset held with all requests valid
    rst_n = 1'b0; req_valid = 4'hF; rsp_ready = 1'b0;
    #12;
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_rsp_sum",   rsp_sum, 32'd0);
    chk("rst_rsp_id",    {30'd0, rsp_id}, 32'd0);
    rst_n = 1'b1; #1;
    chk("t1_first_grant", {28'd0, req_ready}, 32'h1);
    tick();
    chk("t1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("t1_rsp_id",    {30'd0, rsp_id}, 32'd0);
    chk("t1_rsp_sum",   rsp_sum, 32'd107);
    req_valid = 4'h0; rsp_ready = 1'b1; #1;
    chk("t1_no_req_ready", {28'd0, req_ready}, 32'd0);
    tick();
    chk("t1_drained", {31'd0, rsp_valid}, 32'd0);

    // T2 single request from id 2
    set_op(2, 32'd1000, 32'd5678);
    req_valid = 4'b0100; #1;
    chk("t2_ready", {28'd0, req_ready}, 32'h4);
    tick();
    req_valid = 4'h0;
    chk("t2_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("t2_rsp_id",    {30'd0, rsp_id}, 32'd2);
    chk("t2_rsp_sum",   rsp_sum, 32'd6678);
    tick();
    chk("t2_drained", {31'd0, rsp_valid}, 32'd0);

    // T5 wrap / saturation via id 3 (also leaves last_grant=3)
    set_op(3, 32'hFFFF_FFFF, 32'd2);
    req_valid = 4'b1000; #1;
    chk("t5_ready", {28'd0, req_ready}, 32'h8);
    tick();
    req_valid = 4'h0;
    chk("t5_rsp_id",  {30'd0, rsp_id}, 32'd3);
    chk("t5_rsp_sum", rsp_sum, exp_wrap);
    tick();
    chk("t5_drained", {31'd0, rsp_valid}, 32'd0);

    // T3 fairness with all requesting, one result per cycle
    for (int i = 0; i < NREQ; i++) set_op(i, 32'd10 * (i + 1), i);
    req_valid = 4'hF; #1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t3_ready_%0d", k), {28'd0, req_ready}, 32'd1 << ord[k]);
      tick();
      chk($sformatf("t3_valid_%0d", k), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("t3_id_%0d", k),    {30'd0, rsp_id}, ord[k]);
      chk($sformatf("t3_sum_%0d", k),   rsp_sum, 32'd10 * (ord[k] + 1) + ord[k]);
    end

    // T4 backpressure: slot holds id 0 result (sum 10)
    rsp_ready = 1'b0; #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t4_ready_%0d", k), {28'd0, req_ready}, 32'd0);
      chk($sformatf("t4_valid_%0d", k), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("t4_id_%0d", k),    {30'd0, rsp_id}, 32'd0);
      chk($sformatf("t4_sum_%0d", k),   rsp_sum, 32'd10);
      tick();
    end
    rsp_ready = 1'b1; #1;
    chk("t4_resume_ready", {28'd0, req_ready}, 32'h2);
    tick();
    chk("t4_resume_id",  {30'd0, rsp_id}, 32'd1);
    chk("t4_resume_sum", rsp_sum, 32'd21);

    // T6 reset while FULL
    rsp_ready = 1'b0; #1;
    chk("t6_full", {31'd0, rsp_valid}, 32'd1);
    rst_n = 1'b0; #1;
    chk("t6_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("t6_rsp_sum",   rsp_sum, 32'd0);
    chk("t6_rsp_id",    {30'd0, rsp_id}, 32'd0);
    chk("t6_req_ready", {28'd0, req_ready}, 32'd0);
    rst_n = 1'b1; rsp_ready = 1'b1; #1;
    chk("t6_prio0", {28'd0, req_ready}, 32'h1);
    tick();
    chk("t6_rsp_id_after", {30'd0, rsp_id}, 32'd0);
    chk("t6_rsp_sum_after", rsp_sum, 32'd10);
    req_valid = 4'h0;
    tick();
    chk("t6_drained", {31'd0, rsp_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
